grf_writeback_port: RTL and testbench



---
 rtl/grf_writeback_port.sv | 120 ++++++++++++
 tb/tb_grf_writeback_port.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grf_writeback_port.sv
// ---------------------------------------------------------------------------
// grf_writeback_port
//
// General register file at the end of the writeback path. The value chosen
// by the writeback mux (ALU result, memory data or PC+4) is committed here.
// The decode stage reads two registers combinationally. A registered trace
// channel reports every committed write so it can be compared against a
// reference register-write log.
//
// Parameters:
//   DW         - width of each register and of the read/write data
//   BYPASS     - 1: a read of the register being written this cycle returns
//                wd (write-through); 0: it returns the stored value
//   TRACE_ZERO - 1: writes addressed to register 0 still emit a trace beat
//
// Ports:
//   clk          - system clock, all state changes on the rising edge
//   reset_n      - asynchronous active-low reset
//   we           - register write enable
//   a1, a2       - read addresses (rs, rt)
//   a3           - write address (already selected upstream)
//   wd           - write data from the writeback mux
//   pc           - PC of the instruction performing the write
//   rd1, rd2     - combinational read data
//   trace_valid  - one-cycle pulse per committed (traced) write
//   trace_pc     - PC of the traced write
//   trace_addr   - register index of the traced write
//   trace_data   - data of the traced write
// ---------------------------------------------------------------------------
module grf_writeback_port #(
    parameter int DW         = 32,
    parameter bit BYPASS     = 1'b0,
    parameter bit TRACE_ZERO = 1'b0
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          we,
    input  logic [4:0]    a1,
    input  logic [4:0]    a2,
    input  logic [4:0]    a3,
    input  logic [DW-1:0] wd,
    input  logic [31:0]   pc,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    output logic          trace_valid,
    output logic [31:0]   trace_pc,
    output logic [4:0]    trace_addr,
    output logic [DW-1:0] trace_data
);

    logic [DW-1:0] regs_q [32];

    logic          trace_valid_q;
    logic [31:0]   trace_pc_q;
    logic [4:0]    trace_addr_q;
    logic [DW-1:0] trace_data_q;

    logic          regWrite;
    logic          traceFire;

    // A write to register 0 never reaches storage; the trace may still
    // report it when TRACE_ZERO is set.
    assign regWrite  = we && (a3 != 5'd0);
    assign traceFire = we && ((a3 != 5'd0) || TRACE_ZERO);

    // Register storage. Register 0 is never written, so it stays at its
    // reset value of zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (regWrite) begin
            regs_q[a3] <= wd;
        end
    end

    // Read ports. The zero check comes last so address 0 reads zero even
    // when the write-through path would otherwise select wd.
    always_comb begin
        rd1 = regs_q[a1];
        rd2 = regs_q[a2];
        if (BYPASS && regWrite && (a1 == a3)) begin
            rd1 = wd;
        end
        if (BYPASS && regWrite && (a2 == a3)) begin
            rd2 = wd;
        end
        if (a1 == 5'd0) begin
            rd1 = '0;
        end
        if (a2 == 5'd0) begin
            rd2 = '0;
        end
    end

    // Trace channel: valid pulses for one cycle per traced write, while
    // the payload fields keep the last traced write between pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trace_valid_q <= 1'b0;
            trace_pc_q    <= '0;
            trace_addr_q  <= '0;
            trace_data_q  <= '0;
        end else begin
            trace_valid_q <= traceFire;
            if (traceFire) begin
                trace_pc_q   <= pc;
                trace_addr_q <= a3;
                trace_data_q <= wd;
            end
        end
    end

    assign trace_valid = trace_valid_q;
    assign trace_pc    = trace_pc_q;
    assign trace_addr  = trace_addr_q;
    assign trace_data  = trace_data_q;

endmodule

// File: tb/tb_grf_writeback_port.sv
// ---------------------------------------------------------------------------
// tb_grf_writeback_port
//
// Drives two register-file instances with identical inputs:
//   dut0 - BYPASS=0, TRACE_ZERO=0
//   dut1 - BYPASS=1, TRACE_ZERO=1
// Expected trace beats are queued per instance when a write is driven and
// popped when the trace channel should report it.
// ---------------------------------------------------------------------------
module tb_grf_writeback_port;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  addr;
        logic [31:0] data;
    } beat_t;

    logic        clk;
    logic        reset_n;
    logic        we;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pcIn;

    logic [31:0] rd1 [2];
    logic [31:0] rd2 [2];
    logic        tv  [2];
    logic [31:0] tpc [2];
    logic [4:0]  ta  [2];
    logic [31:0] td  [2];

    beat_t       q    [2][$];
    beat_t       last [2];
    logic        expV;
    logic [31:0] expRd1 [2];

    int assertCount = 0;
    int failCount   = 0;

    grf_writeback_port #(.DW(32), .BYPASS(1'b0), .TRACE_ZERO(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n), .we(we), .a1(a1), .a2(a2), .a3(a3),
        .wd(wd), .pc(pcIn), .rd1(rd1[0]), .rd2(rd2[0]), .trace_valid(tv[0]),
        .trace_pc(tpc[0]), .trace_addr(ta[0]), .trace_data(td[0])
    );

    grf_writeback_port #(.DW(32), .BYPASS(1'b1), .TRACE_ZERO(1'b1)) dut1 (
        .clk(clk), .reset_n(reset_n), .we(we), .a1(a1), .a2(a2), .a3(a3),
        .wd(wd), .pc(pcIn), .rd1(rd1[1]), .rd2(rd2[1]), .trace_valid(tv[1]),
        .trace_pc(tpc[1]), .trace_addr(ta[1]), .trace_data(td[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one write and queue the trace beat each instance should emit.
    task automatic applyStimulus(input logic [4:0] addr, input logic [31:0] data,
                                 input logic [31:0] pcv);
        beat_t b;
        we   = 1'b1;
        a3   = addr;
        wd   = data;
        pcIn = pcv;
        b = '{pc: pcv, addr: addr, data: data};
        if (addr != 5'd0) q[0].push_back(b);
        q[1].push_back(b);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        we = 1'b0; a1 = 5'd5; a2 = 5'd0; a3 = 5'd0; wd = '0; pcIn = '0;
        last[0] = '0; last[1] = '0;
        #1;
        for (int d = 0; d < 2; d++) begin
            assertCount++;
            if (tv[d] !== 1'b0 || rd1[d] !== 32'h0) begin
                failCount++;
                $display("[TB] FAIL por dut%0d: tv=%b rd1=%h, want tv=0 rd1=0", d, tv[d], rd1[d]);
            end
        end
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(5'd5, 32'h0000_1234, 32'h0000_0100);
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            assertCount++;
            expV = (q[d].size() != 0);
            if (expV) last[d] = q[d].pop_front();
            if (tv[d] !== expV || {tpc[d], ta[d], td[d]} !== last[d]) begin
                failCount++;
                $display("[TB] FAIL preload_trace dut%0d: got %b %h/%h/%h want %b %h/%h/%h", d,
                         tv[d], tpc[d], ta[d], td[d], expV, last[d].pc, last[d].addr, last[d].data);
            end
        end
        @(negedge clk);
        we = 1'b0; a1 = 5'd5;
        #1;
        for (int d = 0; d < 2; d++) begin
            assertCount++;
            if (rd1[d] !== 32'h0000_1234) begin
                failCount++;
                $display("[TB] FAIL preload_read dut%0d: rd1=%h want 00001234", d, rd1[d]);
            end
        end
        // Assert reset between edges: state must clear without a clock.
        #1 reset_n = 1'b0;
        #1;
        last[0] = '0; last[1] = '0;
        for (int d = 0; d < 2; d++) begin
            assertCount++;
            if (rd1[d] !== 32'h0 || tv[d] !== 1'b0 || {tpc[d], ta[d], td[d]} !== 69'd0) begin
                failCount++;
                $display("[TB] FAIL async_reset dut%0d: rd1=%h tv=%b trace=%h/%h/%h want all 0",
                         d, rd1[d], tv[d], tpc[d], ta[d], td[d]);
            end
        end
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            a1 = 5'(i);
            a2 = 5'(31 - i);
            #1;
            for (int d = 0; d < 2; d++) begin
                assertCount++;
                if (rd1[d] !== 32'h0 || rd2[d] !== 32'h0) begin
                    failCount++;
                    $display("[TB] FAIL reset_regs dut%0d a1=%0d: rd1=%h rd2=%h want 0", d, i, rd1[d], rd2[d]);
                end
            end
        end
    endtask

    task automatic test_basic();
        @(negedge clk);
        applyStimulus(5'd8, 32'hDEAD_BEEF, 32'h0000_3000);
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            assertCount++;
            expV = (q[d].size() != 0);
            if (expV) last[d] = q[d].pop_front();
            if (tv[d] !== expV || {tpc[d], ta[d], td[d]} !== last[d]) begin
                failCount++;
                $display("[TB] FAIL basic_trace dut%0d: got %b %h/%h/%h want %b %h/%h/%h", d,
                         tv[d], tpc[d], ta[d], td[d], expV, last[d].pc, last[d].addr, last[d].data);
            end
        end
        @(negedge clk);
        we = 1'b0; a1 = 5'd8; a2 = 5'd8;
        #1;
        for (int d = 0; d < 2; d++) begin
            assertCount++;
            if (rd1[d] !== 32'hDEAD_BEEF || rd2[d] !== 32'hDEAD_BEEF) begin
                failCount++;
                $display("[TB] FAIL basic_read dut%0d: rd1=%h rd2=%h want deadbeef", d, rd1[d], rd2[d]);
            end
        end
        // No write this cycle: valid must drop, payload must hold.
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            assertCount++;
            expV = (q[d].size() != 0);
            if (expV) last[d] = q[d].pop_front();
            if (tv[d] !== expV || {tpc[d], ta[d], td[d]} !== last[d]) begin
                failCount++;
                $display("[TB] FAIL basic_pulse dut%0d: got %b %h/%h/%h want %b %h/%h/%h", d,
                         tv[d], tpc[d], ta[d], td[d], expV, last[d].pc, last[d].addr, last[d].data);
            end
        end
    endtask

    task automatic test_reg_zero();
        @(negedge clk);
        applyStimulus(5'd0, 32'hFFFF_FFFF, 32'h0000_3004);
        a1 = 5'd0; a2 = 5'd8;
        #1;
        for (int d = 0; d < 2; d++) begin
            assertCount++;
            if (rd1[d] !== 32'h0 || rd2[d] !== 32'hDEAD_BEEF) begin
                failCount++;
                $display("[TB] FAIL zero_bypass dut%0d: rd1=%h rd2=%h want 0/deadbeef", d, rd1[d], rd2[d]);
            end
        end
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            assertCount++;
            expV = (q[d].size() != 0);
            if (expV) last[d] = q[d].pop_front();
            if (tv[d] !== expV || {tpc[d], ta[d], td[d]} !== last[d]) begin
                failCount++;
                $display("[TB] FAIL zero_trace dut%0d: got %b %h/%h/%h want %b %h/%h/%h", d,
                         tv[d], tpc[d], ta[d], td[d], expV, last[d].pc, last[d].addr, last[d].data);
            end
        end
        @(negedge clk);
        we = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            assertCount++;
            if (rd1[d] !== 32'h0) begin
                failCount++;
                $display("[TB] FAIL zero_read dut%0d: rd1=%h want 0", d, rd1[d]);
            end
        end
    endtask

    task automatic test_bypass();
        applyStimulus(5'd9, 32'h0000_0011, 32'h0000_3010);
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            assertCount++;
            expV = (q[d].size() != 0);
            if (expV) last[d] = q[d].pop_front();
            if (tv[d] !== expV || {tpc[d], ta[d], td[d]} !== last[d]) begin
                failCount++;
                $display("[TB] FAIL bypass_pre_trace dut%0d: got %b %h/%h/%h want %b %h/%h/%h", d,
                         tv[d], tpc[d], ta[d], td[d], expV, last[d].pc, last[d].addr, last[d].data);
            end
        end
        @(negedge clk);
        applyStimulus(5'd9, 32'h0000_0022, 32'h0000_3014);
        a1 = 5'd9; a2 = 5'd8;
        expRd1[0] = 32'h0000_0011;
        expRd1[1] = 32'h0000_0022;
        #1;
        for (int d = 0; d < 2; d++) begin
            assertCount++;
            if (rd1[d] !== expRd1[d] || rd2[d] !== 32'hDEAD_BEEF) begin
                failCount++;
                $display("[TB] FAIL bypass_same_cycle dut%0d: rd1=%h rd2=%h want %h/deadbeef",
                         d, rd1[d], rd2[d], expRd1[d]);
            end
        end
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            assertCount++;
            expV = (q[d].size() != 0);
            if (expV) last[d] = q[d].pop_front();
            if (tv[d] !== expV || {tpc[d], ta[d], td[d]} !== last[d] || rd1[d] !== 32'h0000_0022) begin
                failCount++;
                $display("[TB] FAIL bypass_after_edge dut%0d: rd1=%h tv=%b %h/%h/%h want 00000022 %b %h/%h/%h",
                         d, rd1[d], tv[d], tpc[d], ta[d], td[d], expV, last[d].pc, last[d].addr, last[d].data);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  addrs [3];
        logic [31:0] datas [3];
        addrs[0] = 5'd31; datas[0] = 32'h0000_3008;
        addrs[1] = 5'd2;  datas[1] = 32'h0000_0007;
        addrs[2] = 5'd31; datas[2] = 32'h0000_300C;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            applyStimulus(addrs[i], datas[i], 32'h0000_3020 + 32'(4 * i));
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++) begin
                assertCount++;
                expV = (q[d].size() != 0);
                if (expV) last[d] = q[d].pop_front();
                if (tv[d] !== expV || {tpc[d], ta[d], td[d]} !== last[d]) begin
                    failCount++;
                    $display("[TB] FAIL b2b_trace%0d dut%0d: got %b %h/%h/%h want %b %h/%h/%h", i, d,
                             tv[d], tpc[d], ta[d], td[d], expV, last[d].pc, last[d].addr, last[d].data);
                end
            end
        end
        @(negedge clk);
        we = 1'b0; a1 = 5'd31; a2 = 5'd2;
        #1;
        for (int d = 0; d < 2; d++) begin
            assertCount++;
            if (rd1[d] !== 32'h0000_300C || rd2[d] !== 32'h0000_0007) begin
                failCount++;
                $display("[TB] FAIL b2b_final dut%0d: rd1=%h rd2=%h want 0000300c/00000007", d, rd1[d], rd2[d]);
            end
        end
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            assertCount++;
            expV = (q[d].size() != 0);
            if (expV) last[d] = q[d].pop_front();
            if (tv[d] !== expV || {tpc[d], ta[d], td[d]} !== last[d]) begin
                failCount++;
                $display("[TB] FAIL b2b_idle dut%0d: got %b %h/%h/%h want %b %h/%h/%h", d,
                         tv[d], tpc[d], ta[d], td[d], expV, last[d].pc, last[d].addr, last[d].data);
            end
        end
    endtask

    task automatic test_reset_mid_write();
        @(negedge clk);
        // This write is killed by reset, so nothing is queued for it.
        we = 1'b1; a3 = 5'd4; wd = 32'h0000_00AA; pcIn = 32'h0000_3040;
        #3 reset_n = 1'b0;
        #1;
        last[0] = '0; last[1] = '0;
        for (int d = 0; d < 2; d++) begin
            assertCount++;
            if (tv[d] !== 1'b0 || {tpc[d], ta[d], td[d]} !== 69'd0) begin
                failCount++;
                $display("[TB] FAIL mid_reset_trace dut%0d: tv=%b %h/%h/%h want all 0",
                         d, tv[d], tpc[d], ta[d], td[d]);
            end
        end
        @(posedge clk);
        #3 reset_n = 1'b1;
        @(negedge clk);
        we = 1'b0; a1 = 5'd4; a2 = 5'd8;
        #1;
        for (int d = 0; d < 2; d++) begin
            assertCount++;
            if (rd1[d] !== 32'h0 || rd2[d] !== 32'h0) begin
                failCount++;
                $display("[TB] FAIL mid_reset_regs dut%0d: rd1=%h rd2=%h want 0/0", d, rd1[d], rd2[d]);
            end
        end
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            assertCount++;
            expV = (q[d].size() != 0);
            if (expV) last[d] = q[d].pop_front();
            if (tv[d] !== expV || {tpc[d], ta[d], td[d]} !== last[d]) begin
                failCount++;
                $display("[TB] FAIL mid_reset_nobeat dut%0d: got %b %h/%h/%h want %b %h/%h/%h", d,
                         tv[d], tpc[d], ta[d], td[d], expV, last[d].pc, last[d].addr, last[d].data);
            end
        end
        @(negedge clk);
        applyStimulus(5'd4, 32'h0000_00BB, 32'h0000_3044);
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            assertCount++;
            expV = (q[d].size() != 0);
            if (expV) last[d] = q[d].pop_front();
            if (tv[d] !== expV || {tpc[d], ta[d], td[d]} !== last[d]) begin
                failCount++;
                $display("[TB] FAIL post_reset_trace dut%0d: got %b %h/%h/%h want %b %h/%h/%h", d,
                         tv[d], tpc[d], ta[d], td[d], expV, last[d].pc, last[d].addr, last[d].data);
            end
        end
        @(negedge clk);
        we = 1'b0; a1 = 5'd4;
        #1;
        for (int d = 0; d < 2; d++) begin
            assertCount++;
            if (rd1[d] !== 32'h0000_00BB) begin
                failCount++;
                $display("[TB] FAIL post_reset_read dut%0d: rd1=%h want 000000bb", d, rd1[d]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reg_zero();
        test_bypass();
        test_back_to_back();
        test_reset_mid_write();
        for (int d = 0; d < 2; d++) begin
            assertCount++;
            if (q[d].size() != 0) begin
                failCount++;
                $display("[TB] FAIL scoreboard_drain dut%0d: %0d beats left, want 0", d, q[d].size());
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
